// File: rtl/loop_pulse_gen_if.sv
// Bus bundle for loop_pulse_gen: control, phase lengths and status.
// Optional macro LPG_DUTY_EN adds the independent low_len field.
interface loop_pulse_gen_if #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned REP_W = 8
);
  logic             start;
  logic             stop;
  logic             mode;
  logic [CNT_W-1:0] high_len;
`ifdef LPG_DUTY_EN
  logic [CNT_W-1:0] low_len;
`endif
  logic [REP_W-1:0] repeat_n;
  logic             wave_out;
  logic             busy;
  logic             done;
  logic [REP_W-1:0] pulse_cnt;

  // Controller side: drives requests, observes status
  modport master (
    output start, stop, mode, high_len,
`ifdef LPG_DUTY_EN
    output low_len,
`endif
    output repeat_n,
    input  wave_out, busy, done, pulse_cnt
  );

  // Generator side
  modport slave (
    input  start, stop, mode, high_len,
`ifdef LPG_DUTY_EN
    input  low_len,
`endif
    input  repeat_n,
    output wave_out, busy, done, pulse_cnt
  );
endinterface

// File: rtl/loop_pulse_gen.sv
// Repeating / free-running pulse train generator (IDLE -> HIGH -> LOW loop).
// Optional macro LPG_DUTY_EN: independent low_len; otherwise LOW lasts high_len.
module loop_pulse_gen #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned REP_W = 8
) (
  input logic              Clk,
  input logic              Rst,
  loop_pulse_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             mode_q;
  logic [CNT_W-1:0] hi_len_q, lo_len_q;
  logic [REP_W-1:0] rep_q;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [REP_W-1:0] pulse_q, pulse_d;
  logic             wave_q, wave_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             latch_c;

  logic             accept_c;
  logic             zero_rep_c;
  logic [CNT_W-1:0] hi_in_c, lo_in_c;
  logic             phase_end_c;
  logic [REP_W-1:0] pulse_inc_c;
  logic             last_pulse_c;

  // Decode of inputs and running counters shared by both comb processes
  always_comb begin
    accept_c     = bus.start & ~bus.stop;
    zero_rep_c   = ~bus.mode & (bus.repeat_n == '0);
    hi_in_c      = (bus.high_len == '0) ? CNT_W'(1) : bus.high_len;
`ifdef LPG_DUTY_EN
    lo_in_c      = (bus.low_len == '0) ? CNT_W'(1) : bus.low_len;
`else
    lo_in_c      = hi_in_c;
`endif
    phase_end_c  = (phase_q == '0);
    pulse_inc_c  = pulse_q + REP_W'(1);
    last_pulse_c = ~mode_q & (pulse_inc_c == rep_q);
  end

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; stop overrides everything in every state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept_c && !zero_rep_c) state_d = HIGH;
      HIGH: begin
        if (bus.stop)         state_d = IDLE;
        else if (phase_end_c) state_d = LOW;
      end
      LOW: begin
        if (bus.stop)         state_d = IDLE;
        else if (phase_end_c) state_d = last_pulse_c ? IDLE : HIGH;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of outputs and phase/pulse counters
  always_comb begin
    wave_d  = (state_d == HIGH);
    busy_d  = (state_d != IDLE);
    done_d  = 1'b0;
    pulse_d = pulse_q;
    phase_d = phase_q;
    latch_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          latch_c = 1'b1;
          pulse_d = '0;
          done_d  = zero_rep_c;
          phase_d = hi_in_c - CNT_W'(1);
        end
      end
      HIGH: begin
        if (!bus.stop) begin
          if (phase_end_c) phase_d = lo_len_q - CNT_W'(1);
          else             phase_d = phase_q - CNT_W'(1);
        end
      end
      LOW: begin
        if (!bus.stop) begin
          if (phase_end_c) begin
            pulse_d = pulse_inc_c;
            phase_d = hi_len_q - CNT_W'(1);
            done_d  = last_pulse_c;
          end else begin
            phase_d = phase_q - CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs; train parameters latched only on accept
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      mode_q   <= 1'b0;
      hi_len_q <= '0;
      lo_len_q <= '0;
      rep_q    <= '0;
      phase_q  <= '0;
      pulse_q  <= '0;
      wave_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (latch_c) begin
        mode_q   <= bus.mode;
        hi_len_q <= hi_in_c;
        lo_len_q <= lo_in_c;
        rep_q    <= bus.repeat_n;
      end
      phase_q <= phase_d;
      pulse_q <= pulse_d;
      wave_q  <= wave_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.wave_out  = wave_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pulse_cnt = pulse_q;

endmodule

// File: doc/loop_pulse_gen.md
LOOP_PULSE_GEN -- requirements
Module: loop_pulse_gen

Interface
REQ-001 The module SHALL provide parameter CNT_W, default 16, giving the width of the high and low phase-length counters.
REQ-002 The module SHALL provide parameter REP_W, default 8, giving the width of the repeat count and pulse counter.
REQ-003 Port Clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 Port Rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port start, input, 1 bit: request to begin a pulse train; sampled only in IDLE.
REQ-006 Port stop, input, 1 bit: abort request; sampled in every state.
REQ-007 Port mode, input, 1 bit: 0 = repeat mode (finite count), 1 = forever mode; latched on accepted start.
REQ-008 Port high_len, input, CNT_W bits: number of cycles wave_out is high per pulse; latched on accepted start.
REQ-009 Port low_len, input, CNT_W bits: number of cycles wave_out is low per pulse; present only when LPG_DUTY_EN is defined.
REQ-010 Port repeat_n, input, REP_W bits: number of pulses in repeat mode; latched on accepted start.
REQ-011 Port wave_out, output, 1 bit: registered generated waveform.
REQ-012 Port busy, output, 1 bit: high while the FSM is in HIGH or LOW.
REQ-013 Port done, output, 1 bit: one-cycle pulse on normal completion of a repeat-mode train.
REQ-014 Port pulse_cnt, output, REP_W bits: number of complete pulses emitted in the current or most recent train.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, HIGH and LOW.
REQ-016 In IDLE, a start sampled high with stop low SHALL latch mode, high_len, low_len and repeat_n, clear pulse_cnt, and enter HIGH on the same edge.
REQ-017 A latched phase length of 0 SHALL be treated as 1.
REQ-018 In repeat mode with repeat_n = 0, an accepted start SHALL stay in IDLE, pulse done for one cycle on the next edge, keep wave_out at 0, and leave pulse_cnt at 0.
REQ-019 wave_out SHALL be 1 exactly while in HIGH and 0 in IDLE and LOW, so the first high cycle immediately follows the start-sampling edge (latency 1 cycle).
REQ-020 HIGH SHALL last exactly the latched high length in cycles and then go to LOW.
REQ-021 LOW SHALL last exactly the latched low length in cycles.
REQ-022 On the last LOW cycle, pulse_cnt SHALL increment by 1, modulo 2^REP_W.
REQ-023 Repeat mode: if the incremented pulse_cnt equals the latched repeat_n, the FSM SHALL go to IDLE and assert done for one cycle; otherwise it SHALL go to HIGH.
REQ-024 Forever mode: after LOW the FSM SHALL always return to HIGH, and pulse_cnt SHALL wrap from 2^REP_W-1 to 0 without stopping.
REQ-025 stop sampled high in HIGH or LOW SHALL force IDLE and wave_out = 0 on that edge, with no done pulse; pulse_cnt SHALL hold its value.
REQ-026 start and stop high together in IDLE: stop SHALL win and the FSM SHALL stay in IDLE.
REQ-027 start while busy SHALL be ignored.
REQ-028 Changes on input ports while busy SHALL NOT affect the running train.

Reset
REQ-029 Rst high SHALL immediately and asynchronously force IDLE, wave_out = 0, busy = 0, done = 0, pulse_cnt = 0, and clear all phase counters and latched values.
REQ-030 Reset asserted mid-train SHALL abort it without a done pulse; after release the block SHALL accept start on the first rising edge.

Configuration
REQ-031 With macro LPG_DUTY_EN defined, port low_len SHALL exist and set the LOW duration independently of high_len.
REQ-032 With LPG_DUTY_EN undefined, port low_len SHALL be absent and LOW SHALL last the latched high_len (50% duty).

Verification
REQ-033 Repeat mode, high_len=3, low_len=2, repeat_n=4: wave_out shows 4 pulses of 3 cycles high and 2 low, then done pulses one cycle after the last LOW cycle; pulse_cnt=4, busy low after 20 cycles.
REQ-034 Forever mode, high_len=1, low_len=1, REP_W=2: wave_out toggles every cycle; pulse_cnt counts 1,2,3,0,1; done is never asserted.
REQ-035 Repeat mode, repeat_n=0: done asserts for one cycle after start; wave_out and busy stay 0.
REQ-036 high_len=0 (and low_len=0 with LPG_DUTY_EN): behaviour is identical to high_len=1 (and low_len=1).
REQ-037 Stop during the second HIGH phase of a repeat_n=5 train: wave_out=0 and busy=0 on the next edge, no done pulse, pulse_cnt=1; a start in the same cycle as stop is ignored.
REQ-038 Rst pulsed mid-LOW: all outputs go to 0 immediately, before the next clock edge; a start on the first edge after release begins a new train normally.
